nonce_sweep_ctrl: RTL and testbench
===================================

NONCE_SWEEP_CTRL -- requirements
Module: nonce_sweep_ctrl

Interface
REQ-001 SHALL have parameter NONCES_PER_BATCH, default 16, the number of nonces the hash core covers per run.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the batch counters.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports, as name direction width meaning:
- clk  in  1  clock.
- reset_n  in  1  async active-low reset.
- cmd_valid  in  1  sweep request.
- cmd_ready  out  1  controller idle, can accept a request.
- start_nonce  in  32  first nonce of the sweep.
- batch_count  in  CNT_W  number of core runs.
- target  in  32  hit threshold on H0.
- abort  in  1  level; stop the sweep after the current run.
- core_start  out  1  one-cycle pulse launching a core run.
- core_nonce_base  out  32  base nonce for the run; valid while the run is active.
- res_valid  in  1  core result strobe.
- res_idx  in  4  nonce offset of the result.
- res_h0  in  32  final H0 for that nonce.
- core_done  in  1  one-cycle pulse; the core run is complete.
- busy  out  1  high when the controller is not in IDLE.
- sweep_done  out  1  one-cycle completion pulse.
- found  out  1  a hit was recorded.
- found_nonce  out  32  hit nonce.
- found_h0  out  32  hit H0.
- aborted  out  1  the sweep ended by abort.
- batches_run  out  CNT_W  number of completed core runs.

Function
REQ-005 SHALL implement the states IDLE, LAUNCH, WAIT, FINISH.
REQ-006 IDLE: cmd_ready=1; on cmd_valid&cmd_ready SHALL latch start_nonce, batch_count and target, clear found, aborted and batches_run, and go to LAUNCH. If batch_count==0 it SHALL go to FINISH instead.
REQ-007 LAUNCH: SHALL assert core_start for exactly one cycle with core_nonce_base=current base, then go to WAIT. core_start SHALL occur 1 cycle after command acceptance.
REQ-008 WAIT: SHALL, on each res_valid, check res_h0 < target (unsigned, strict). The first hit of a run SHALL record found_nonce=base+res_idx (mod 2^32) and found_h0=res_h0; later hits in the same run SHALL be ignored.
REQ-009 A res_valid in the same cycle as core_done SHALL be evaluated before the continuation decision.
REQ-010 On core_done in WAIT: SHALL increment batches_run and set base=base+NONCES_PER_BATCH, wrapping mod 2^32. It SHALL go to FINISH if found, abort, or batches_run+1==batch_count; otherwise it SHALL go to LAUNCH. The next core_start SHALL therefore occur at core_done+2.
REQ-011 abort SHALL be sampled only in WAIT; the run in flight always completes. aborted=1 only if no hit was found and runs remained.
REQ-012 FINISH: SHALL pulse sweep_done for one cycle and return to IDLE. found, found_nonce, found_h0, aborted and batches_run SHALL hold until the next command is accepted.
REQ-013 res_valid and core_done outside WAIT SHALL be ignored.
REQ-014 cmd_valid while busy SHALL be ignored (cmd_ready=0).
REQ-015 target==0 SHALL never produce a hit.

Reset
REQ-016 On reset_n low SHALL asynchronously enter IDLE with every output 0 except cmd_ready=1, and clear all latched registers.
REQ-017 Reset mid-sweep SHALL abandon the sweep without a sweep_done pulse; no core_start SHALL follow until a new command is accepted.

Structure
REQ-018 A shared package bitcoin_pkg SHALL hold NONCES_PER_BATCH, the state enum type and the initial-hash constants used with the hash core.
REQ-019 The hit comparison and first-hit capture SHALL be a sub-module nonce_hit_tracker (clear, res_valid, res_idx, res_h0, base, target -> found, found_nonce, found_h0).
REQ-020 The RTL SHALL be a single always_ff plus combinational next-state logic; no memories.

Verification
REQ-021 Scenario: start_nonce=0, batch_count=3, target=0; each run returns 16 results then core_done -> core_start at bases 0, 16, 32; sweep_done; found=0, batches_run=3.
REQ-022 Scenario: start_nonce=0x100, target=0x00001000; run 1 returns idx 5 h0=0x00000FFF and idx 9 h0=0x10 -> found_nonce=0x105, found_h0=0xFFF; stop after run 1, batches_run=1.
REQ-023 Scenario: start_nonce=0xFFFFFFF8, batch_count=2, hit at idx 10 of run 2 -> second base=0x00000008, found_nonce=0x00000012.
REQ-024 Scenario: batch_count=5, abort raised during run 2 -> run 2 completes; sweep_done; aborted=1; batches_run=2; no third core_start.
REQ-025 Scenario: batch_count=0 -> no core_start; sweep_done 2 cycles after acceptance; all flags 0.
REQ-026 Scenario: reset_n pulsed low during WAIT of run 1 -> outputs at reset values immediately; no sweep_done; cmd_ready=1.

Source files
------------

// File: rtl/bitcoin_pkg.sv
// Shared definitions for the nonce sweep controller and its hash core.
`timescale 1ns/1ps
package bitcoin_pkg;

  // Number of nonces the hash core covers per run.
  localparam int unsigned NONCES_PER_BATCH = 16;

  // Sweep controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } sweep_state_e;

  // SHA-256 initial hash values used by the hash core.
  localparam logic [31:0] SHA256_H0_INIT = 32'h6a09e667;
  localparam logic [31:0] SHA256_H1_INIT = 32'hbb67ae85;
  localparam logic [31:0] SHA256_H2_INIT = 32'h3c6ef372;
  localparam logic [31:0] SHA256_H3_INIT = 32'ha54ff53a;
  localparam logic [31:0] SHA256_H4_INIT = 32'h510e527f;
  localparam logic [31:0] SHA256_H5_INIT = 32'h9b05688c;
  localparam logic [31:0] SHA256_H6_INIT = 32'h1f83d9ab;
  localparam logic [31:0] SHA256_H7_INIT = 32'h5be0cd19;

endpackage

// File: rtl/nonce_hit_tracker.sv
// Compares each core result against the target and captures the first hit.
`timescale 1ns/1ps
module nonce_hit_tracker (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        res_valid_i,
  input  logic [3:0]  res_idx_i,
  input  logic [31:0] res_h0_i,
  input  logic [31:0] base_i,
  input  logic [31:0] target_i,
  output logic        found_o,
  output logic [31:0] found_nonce_o,
  output logic [31:0] found_h0_o
);

  logic        found_q, found_d;
  logic [31:0] nonce_q, nonce_d;
  logic [31:0] h0_q, h0_d;
  logic        hit;

  // Strict unsigned compare: a zero target can never hit.
  assign hit = res_valid_i && (res_h0_i < target_i);

  // Clear has priority; only the first hit after a clear is kept.
  always_comb begin
    found_d = found_q;
    nonce_d = nonce_q;
    h0_d    = h0_q;
    if (clear_i) begin
      found_d = 1'b0;
      nonce_d = '0;
      h0_d    = '0;
    end else if (hit && !found_q) begin
      found_d = 1'b1;
      nonce_d = base_i + {28'd0, res_idx_i};
      h0_d    = res_h0_i;
    end
  end

  // Hit record registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found_q <= 1'b0;
      nonce_q <= '0;
      h0_q    <= '0;
    end else begin
      found_q <= found_d;
      nonce_q <= nonce_d;
      h0_q    <= h0_d;
    end
  end

  assign found_o       = found_q;
  assign found_nonce_o = nonce_q;
  assign found_h0_o    = h0_q;

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep controller: launches hash-core runs over consecutive nonce
// batches until a hit, an abort, or the requested batch count is reached.
`timescale 1ns/1ps
module nonce_sweep_ctrl #(
  parameter int unsigned NONCES_PER_BATCH = bitcoin_pkg::NONCES_PER_BATCH,
  parameter int unsigned CNT_W            = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      start_nonce,
  input  logic [CNT_W-1:0] batch_count,
  input  logic [31:0]      target,
  input  logic             abort,
  output logic             core_start,
  output logic [31:0]      core_nonce_base,
  input  logic             res_valid,
  input  logic [3:0]       res_idx,
  input  logic [31:0]      res_h0,
  input  logic             core_done,
  output logic             busy,
  output logic             sweep_done,
  output logic             found,
  output logic [31:0]      found_nonce,
  output logic [31:0]      found_h0,
  output logic             aborted,
  output logic [CNT_W-1:0] batches_run
);

  import bitcoin_pkg::*;

  sweep_state_e     state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      target_q, target_d;
  logic [CNT_W-1:0] batch_q, batch_d;
  logic [CNT_W-1:0] runs_q, runs_d;
  logic             aborted_q, aborted_d;
  logic             pend_q, pend_d;
  logic             cmd_ready_q, busy_q, core_start_q, sweep_done_q;
  logic             accept, trk_valid, trk_found;

  assign accept    = (state_q == ST_IDLE) && cmd_valid;
  assign trk_valid = res_valid && (state_q == ST_WAIT) && !pend_q;

  nonce_hit_tracker u_hit (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear_i       (accept),
    .res_valid_i   (trk_valid),
    .res_idx_i     (res_idx),
    .res_h0_i      (res_h0),
    .base_i        (base_q),
    .target_i      (target_q),
    .found_o       (trk_found),
    .found_nonce_o (found_nonce),
    .found_h0_o    (found_h0)
  );

  // Next-state logic. core_done only arms pend_q; the continue/stop decision
  // is taken the following cycle so a hit arriving with core_done is already
  // visible in trk_found.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    target_d  = target_q;
    batch_d   = batch_q;
    runs_d    = runs_q;
    aborted_d = aborted_q;
    pend_d    = pend_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          base_d    = start_nonce;
          target_d  = target;
          batch_d   = batch_count;
          runs_d    = '0;
          aborted_d = 1'b0;
          state_d   = (batch_count == '0) ? ST_FINISH : ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        pend_d  = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (trk_found || abort || (runs_q == batch_q)) begin
            aborted_d = !trk_found && abort && (runs_q != batch_q);
            state_d   = ST_FINISH;
          end else begin
            state_d = ST_LAUNCH;
          end
        end else if (core_done) begin
          runs_d = runs_q + CNT_W'(1);
          base_d = base_q + 32'(NONCES_PER_BATCH);
          pend_d = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched command and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      target_q     <= '0;
      batch_q      <= '0;
      runs_q       <= '0;
      aborted_q    <= 1'b0;
      pend_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      target_q     <= target_d;
      batch_q      <= batch_d;
      runs_q       <= runs_d;
      aborted_q    <= aborted_d;
      pend_q       <= pend_d;
      cmd_ready_q  <= (state_d == ST_IDLE);
      busy_q       <= (state_d != ST_IDLE);
      core_start_q <= (state_d == ST_LAUNCH);
      sweep_done_q <= (state_q == ST_FINISH);
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign busy            = busy_q;
  assign core_start      = core_start_q;
  assign sweep_done      = sweep_done_q;
  assign core_nonce_base = base_q;
  assign found           = trk_found;
  assign aborted         = aborted_q;
  assign batches_run     = runs_q;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Directed scoreboard bench for nonce_sweep_ctrl with a behavioural hash core.
`timescale 1ns/1ps
module tb_nonce_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] start_nonce;
  logic [15:0] batch_count;
  logic [31:0] target;
  logic        abort;
  logic        core_start;
  logic [31:0] core_nonce_base;
  logic        res_valid;
  logic [3:0]  res_idx;
  logic [31:0] res_h0;
  logic        core_done;
  logic        busy;
  logic        sweep_done;
  logic        found;
  logic [31:0] found_nonce;
  logic [31:0] found_h0;
  logic        aborted;
  logic [15:0] batches_run;

  nonce_sweep_ctrl #(.NONCES_PER_BATCH(16), .CNT_W(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .start_nonce     (start_nonce),
    .batch_count     (batch_count),
    .target          (target),
    .abort           (abort),
    .core_start      (core_start),
    .core_nonce_base (core_nonce_base),
    .res_valid       (res_valid),
    .res_idx         (res_idx),
    .res_h0          (res_h0),
    .core_done       (core_done),
    .busy            (busy),
    .sweep_done      (sweep_done),
    .found           (found),
    .found_nonce     (found_nonce),
    .found_h0        (found_h0),
    .aborted         (aborted),
    .batches_run     (batches_run)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        f;
    logic [31:0] fn;
    logic [31:0] fh;
    logic        ab;
    logic [15:0] br;
  } res_t;

  logic [31:0] exp_base [$];
  res_t        exp_res  [$];
  logic [31:0] h0_tab   [16];
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic f, input logic [31:0] fn, input logic [31:0] fh,
                              input logic ab, input logic [15:0] br);
    res_t r;
    r.f = f; r.fn = fn; r.fh = fh; r.ab = ab; r.br = br;
    return r;
  endfunction

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 16; i++) h0_tab[i] = v;
  endtask

  // Scoreboard: every core_start and sweep_done must match a queued expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (core_start === 1'b1) begin
        chk("core_start_expected", 32'(exp_base.size() != 0), 32'd1);
        if (exp_base.size() != 0) chk("core_nonce_base", core_nonce_base, exp_base.pop_front());
      end
      if (sweep_done === 1'b1) begin
        chk("sweep_done_expected", 32'(exp_res.size() != 0), 32'd1);
        if (exp_res.size() != 0) begin
          res_t r;
          r = exp_res.pop_front();
          chk("res_found", 32'(found), 32'(r.f));
          chk("res_found_nonce", found_nonce, r.fn);
          chk("res_found_h0", found_h0, r.fh);
          chk("res_aborted", 32'(aborted), 32'(r.ab));
          chk("res_batches_run", 32'(batches_run), 32'(r.br));
          chk("res_busy_low", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_core_start"}, 32'(core_start), 32'd0);
    chk({tag, "_sweep_done"}, 32'(sweep_done), 32'd0);
    chk({tag, "_found"}, 32'(found), 32'd0);
    chk({tag, "_found_nonce"}, found_nonce, 32'd0);
    chk({tag, "_found_h0"}, found_h0, 32'd0);
    chk({tag, "_aborted"}, 32'(aborted), 32'd0);
    chk({tag, "_batches_run"}, 32'(batches_run), 32'd0);
    chk({tag, "_core_nonce_base"}, core_nonce_base, 32'd0);
  endtask

  // Issue a command at a negedge; returns at the negedge after acceptance.
  task automatic send_cmd(input logic [31:0] sn, input logic [15:0] bc, input logic [31:0] tg);
    chk("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
    start_nonce = sn; batch_count = bc; target = tg; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Bounded wait for core_start (which=0) or sweep_done (which=1); the
  // current negedge counts as latency 1.
  task automatic wait_evt(input bit which, input string tag, input int exp_lat);
    int cnt;
    bit seen;
    seen = 1'b0;
    for (cnt = 1; cnt <= 20; cnt++) begin
      if ((which ? sweep_done : core_start) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (exp_lat > 0) chk({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
  endtask

  // Behavioural core: called at the core_start negedge; returns at the
  // negedge after the cycle carrying core_done.
  task automatic core_run(input int nres, input bit done_with_last);
    @(negedge clk);
    for (int i = 0; i < nres; i++) begin
      res_valid = 1'b1;
      res_idx   = 4'(i);
      res_h0    = h0_tab[i];
      if (done_with_last && (i == nres - 1)) core_done = 1'b1;
      @(negedge clk);
    end
    res_valid = 1'b0;
    if (!(done_with_last && nres > 0)) begin
      core_done = 1'b1;
      @(negedge clk);
    end
    core_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2;
    bit saw;
    reset_n = 1'b0; cmd_valid = 1'b0; start_nonce = '0; batch_count = '0; target = '0;
    abort = 1'b0; res_valid = 1'b0; res_idx = '0; res_h0 = '0; core_done = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Three full runs, target 0 never hits; busy command injection ignored.
    fill(32'h0);
    exp_base.push_back(32'd0); exp_base.push_back(32'd16); exp_base.push_back(32'd32);
    exp_res.push_back(mk(1'b0, 32'd0, 32'd0, 1'b0, 16'd3));
    send_cmd(32'd0, 16'd3, 32'd0);
    wait_evt(1'b0, "s1_start1", 1);
    core_run(16, 1'b0);
    wait_evt(1'b0, "s1_start2", 2);
    cmd_valid = 1'b1; start_nonce = 32'hDEADBEEF; batch_count = 16'd7;
    chk("s1_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("s1_cmd_ready_wait", 32'(cmd_ready), 32'd0);
    chk("s1_busy", 32'(busy), 32'd1);
    cmd_valid = 1'b0;
    core_run(16, 1'b0);
    wait_evt(1'b0, "s1_start3", 2);
    core_run(16, 1'b0);
    wait_evt(1'b1, "s1_done", 0);
    @(negedge clk);
    chk("s1_done_pulse", 32'(sweep_done), 32'd0);
    chk("s1_idle_ready", 32'(cmd_ready), 32'd1);

    // First hit recorded, later hit and h0==target ignored; stop after run 1.
    fill(32'hFFFFFFFF);
    h0_tab[2] = 32'h00001000; h0_tab[5] = 32'h00000FFF; h0_tab[9] = 32'h00000010;
    exp_base.push_back(32'h100);
    exp_res.push_back(mk(1'b1, 32'h100 + 32'd5, 32'h00000FFF, 1'b0, 16'd1));
    send_cmd(32'h100, 16'd4, 32'h00001000);
    wait_evt(1'b0, "s2_start1", 1);
    core_run(16, 1'b0);
    wait_evt(1'b1, "s2_done", 0);
    repeat (2) @(negedge clk);

    // Base wraps; hit on the same cycle as core_done stops before run 3.
    b2 = 32'hFFFFFFF8 + 32'd16;
    exp_base.push_back(32'hFFFFFFF8); exp_base.push_back(b2);
    exp_res.push_back(mk(1'b1, b2 + 32'd10, 32'h5, 1'b0, 16'd2));
    fill(32'hFFFFFFFF);
    send_cmd(32'hFFFFFFF8, 16'd3, 32'h00001000);
    wait_evt(1'b0, "s3_start1", 1);
    core_run(16, 1'b0);
    wait_evt(1'b0, "s3_start2", 2);
    h0_tab[10] = 32'h5;
    core_run(11, 1'b1);
    wait_evt(1'b1, "s3_done", 0);
    repeat (2) @(negedge clk);

    // Abort during run 2 of 5.
    fill(32'hFFFFFFFF);
    exp_base.push_back(32'h1000); exp_base.push_back(32'h1010);
    exp_res.push_back(mk(1'b0, 32'd0, 32'd0, 1'b1, 16'd2));
    send_cmd(32'h1000, 16'd5, 32'h10);
    wait_evt(1'b0, "s4_start1", 1);
    core_run(16, 1'b0);
    wait_evt(1'b0, "s4_start2", 2);
    abort = 1'b1;
    core_run(16, 1'b0);
    wait_evt(1'b1, "s4_done", 0);
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (core_start === 1'b1) saw = 1'b1;
    end
    abort = 1'b0;
    chk("s4_no_third_start", 32'(saw), 32'd0);
    // Results and core_done in IDLE are ignored; flags hold.
    res_valid = 1'b1; res_idx = 4'd0; res_h0 = 32'h0; core_done = 1'b1;
    @(negedge clk);
    res_valid = 1'b0; core_done = 1'b0;
    @(negedge clk);
    chk("s4_hold_found", 32'(found), 32'd0);
    chk("s4_hold_aborted", 32'(aborted), 32'd1);
    chk("s4_hold_batches", 32'(batches_run), 32'd2);

    // Zero batch count: no core run, done two cycles after acceptance.
    exp_res.push_back(mk(1'b0, 32'd0, 32'd0, 1'b0, 16'd0));
    send_cmd(32'h5555, 16'd0, 32'hFFFFFFFF);
    wait_evt(1'b1, "s5_done", 2);
    repeat (2) @(negedge clk);

    // Reset mid-run abandons the sweep.
    exp_base.push_back(32'h2000);
    fill(32'hFFFFFFFF);
    send_cmd(32'h2000, 16'd3, 32'hFFFFFFFF);
    wait_evt(1'b0, "s6_start1", 1);
    @(negedge clk);
    res_valid = 1'b1; res_idx = 4'd3; res_h0 = 32'h5;
    @(negedge clk);
    res_valid = 1'b0;
    chk("s6_found_before_reset", 32'(found), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("s6_reset");
    @(negedge clk);
    reset_n = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (core_start === 1'b1 || sweep_done === 1'b1) saw = 1'b1;
    end
    chk("s6_quiet_after_reset", 32'(saw), 32'd0);
    chk("s6_cmd_ready", 32'(cmd_ready), 32'd1);

    chk("sb_bases_drained", 32'(exp_base.size()), 32'd0);
    chk("sb_results_drained", 32'(exp_res.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
